// File: rtl/key_debounce.sv
// key_debounce: synchronises four active-low key switches, debounces each
// on a slow sample tick, and priority-encodes the held keys into a
// registered note index with a valid flag and a one-cycle press strobe.

// Per-key lane: two-flop synchroniser plus a debounce counter. The lane
// only accepts a new key state after DEB_TICKS consecutive differing
// samples; any sample that agrees with the current state restarts the count.
module key_debounce_lane #(
  parameter int DEB_TICKS = 200
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic sw_n,
  output logic key_dn
);
  localparam int CW = $clog2(DEB_TICKS) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_TICKS - 1);

  logic [1:0]    sync_q, sync_d;
  logic          key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          raw_dn;

  // Synchroniser shift (stage 0 samples the raw pin) and debounce next-state.
  always_comb begin
    sync_d = {sync_q[0], sw_n};
    raw_dn = ~sync_q[1];
    key_d  = key_q;
    cnt_d  = cnt_q;
    if (tick) begin
      if (raw_dn == key_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        key_d = raw_dn;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Lane state; synchroniser resets to the released level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
      key_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      key_q  <= key_d;
      cnt_q  <= cnt_d;
    end
  end

  assign key_dn = key_q;
endmodule

// Top: sample-tick generator, four debounce lanes, priority encoder and
// the registered note outputs.
module key_debounce #(
  parameter int TICK_DIV  = 2500,
  parameter int DEB_TICKS = 200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  output logic [3:0] KEY_DN,
  output logic [1:0] NOTE,
  output logic       NOTE_VALID,
  output logic       PRESS,
  output logic       TICK
);
  localparam int NUM_LANES = 4;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [NUM_LANES-1:0] sw_n;
  logic [NUM_LANES-1:0] key_dn;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                 tick_q, tick_d;
  logic [1:0]           note_q, note_d;
  logic                 valid_q, valid_d;
  logic                 press_q, press_d;

  assign sw_n = {SW3, SW2, SW1, SW0};

  // Tick counter wraps at TICK_DIV-1; TICK is registered so it lands the
  // cycle after the counter reads its last value.
  always_comb begin
    tick_d     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + 1'b1;
  end

  // Tick generator state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    key_debounce_lane #(.DEB_TICKS(DEB_TICKS)) u_lane (
      .CLK    (CLK),
      .RST    (RST),
      .tick   (tick_q),
      .sw_n   (sw_n[i]),
      .key_dn (key_dn[i])
    );
  end

  // Lowest held index wins; PRESS fires on a new note or an index change.
  always_comb begin
    note_d  = '0;
    valid_d = |key_dn;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (key_dn[i]) note_d = 2'(i);
    end
    press_d = valid_d & (~valid_q | (note_d != note_q));
  end

  // Registered note outputs, updated every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      note_q  <= '0;
      valid_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      note_q  <= note_d;
      valid_q <= valid_d;
      press_q <= press_d;
    end
  end

  assign KEY_DN     = key_dn;
  assign NOTE       = note_q;
  assign NOTE_VALID = valid_q;
  assign PRESS      = press_q;
  assign TICK       = tick_q;
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with TICK_DIV=4, DEB_TICKS=3.
// cyc counts rising edges since RST last deasserted; outputs are sampled
// on the falling edge, inputs are driven right after sampling.
module tb_key_debounce;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'hF;
  logic [3:0] key_dn;
  logic [1:0] note;
  logic       note_valid, press, tick;

  int cyc       = 0;
  int n_pass    = 0;
  int n_total   = 0;
  int press_cnt = 0;
  int p0        = 0;

  key_debounce #(.TICK_DIV(4), .DEB_TICKS(3)) dut (
    .CLK        (clk),
    .RST        (rst),
    .SW0        (sw[0]),
    .SW1        (sw[1]),
    .SW2        (sw[2]),
    .SW3        (sw[3]),
    .KEY_DN     (key_dn),
    .NOTE       (note),
    .NOTE_VALID (note_valid),
    .PRESS      (press),
    .TICK       (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at cyc %0d", tag, obs, exp, cyc);
  endtask

  // One clock: TICK must pulse every 4th cycle after reset release.
  task automatic adv();
    @(posedge clk);
    if (rst) cyc = 0; else cyc++;
    @(negedge clk);
    if (!rst) chk("tick", 8'(tick), 8'((cyc != 0) && (cyc % 4 == 0)));
    if (press) press_cnt++;
  endtask

  task automatic run_to(input int target);
    if (target <= cyc) chk("run_to_target", 8'(cyc), 8'(target));
    while (cyc < target) adv();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset state and tick cadence
    repeat (3) adv();
    chk("rst_keydn", 8'(key_dn), 8'h0);
    chk("rst_note", 8'(note), 8'h0);
    chk("rst_valid", 8'(note_valid), 8'h0);
    chk("rst_press", 8'(press), 8'h0);
    chk("rst_tick", 8'(tick), 8'h0);
    rst = 1'b0;
    run_to(12);
    chk("idle_valid", 8'(note_valid), 8'h0);

    // 2: clean press of SW2, then release
    sw[2] = 1'b0;
    run_to(24); chk("press2_early", 8'(key_dn), 8'h0);
    run_to(25); chk("press2_keydn", 8'(key_dn), 8'h4);
    chk("press2_valid_lag", 8'(note_valid), 8'h0);
    p0 = press_cnt;
    run_to(26); chk("press2_note", 8'(note), 8'h2);
    chk("press2_valid", 8'(note_valid), 8'h1);
    chk("press2_press", 8'(press), 8'h1);
    run_to(27); chk("press2_press_off", 8'(press), 8'h0);
    chk("press2_note_hold", 8'(note), 8'h2);
    run_to(28); sw[2] = 1'b1;
    run_to(40); chk("rel2_early", 8'(key_dn), 8'h4);
    run_to(41); chk("rel2_keydn", 8'(key_dn), 8'h0);
    chk("rel2_valid_lag", 8'(note_valid), 8'h1);
    run_to(42); chk("rel2_valid", 8'(note_valid), 8'h0);
    chk("rel2_note", 8'(note), 8'h0);
    chk("rel2_press", 8'(press), 8'h0);
    run_to(44); chk("press2_count", 8'(press_cnt - p0), 8'h1);

    // 3: SW0 bounces every 5 cycles for 60 cycles, then settles pressed
    p0 = press_cnt;
    for (int j = 0; j < 12; j++) begin
      sw[0] = j[0];
      for (int k = 0; k < 5; k++) begin
        adv();
        chk("bounce_keydn", 8'(key_dn), 8'h0);
      end
    end
    sw[0] = 1'b0;
    run_to(116); chk("bounce_settle_early", 8'(key_dn), 8'h0);
    run_to(117); chk("bounce_keydn_set", 8'(key_dn), 8'h1);
    run_to(118); chk("bounce_note", 8'(note), 8'h0);
    chk("bounce_valid", 8'(note_valid), 8'h1);
    chk("bounce_press", 8'(press), 8'h1);
    run_to(120); chk("bounce_press_count", 8'(press_cnt - p0), 8'h1);
    sw[0] = 1'b1;
    run_to(136); chk("bounce_rel_keydn", 8'(key_dn), 8'h0);
    chk("bounce_rel_valid", 8'(note_valid), 8'h0);

    // 4: SW1 and SW3 together, then SW1 released
    sw[1] = 1'b0; sw[3] = 1'b0;
    p0 = press_cnt;
    run_to(148); chk("prio_early", 8'(key_dn), 8'h0);
    run_to(149); chk("prio_keydn", 8'(key_dn), 8'hA);
    run_to(150); chk("prio_note", 8'(note), 8'h1);
    chk("prio_valid", 8'(note_valid), 8'h1);
    chk("prio_press", 8'(press), 8'h1);
    run_to(151); chk("prio_press_off", 8'(press), 8'h0);
    run_to(152); sw[1] = 1'b1;
    while (cyc < 164) begin
      adv();
      chk("handover_valid", 8'(note_valid), 8'h1);
    end
    chk("handover_note_hold", 8'(note), 8'h1);
    run_to(165); chk("handover_keydn", 8'(key_dn), 8'h8);
    chk("handover_valid_165", 8'(note_valid), 8'h1);
    run_to(166); chk("handover_note", 8'(note), 8'h3);
    chk("handover_press", 8'(press), 8'h1);
    chk("handover_valid_166", 8'(note_valid), 8'h1);
    run_to(167); chk("handover_press_off", 8'(press), 8'h0);
    chk("prio_press_count", 8'(press_cnt - p0), 8'h2);
    run_to(168); sw[3] = 1'b1;
    run_to(184); chk("prio_rel_keydn", 8'(key_dn), 8'h0);
    chk("prio_rel_valid", 8'(note_valid), 8'h0);

    // 5: reset after the 2nd tick of an SW0 debounce
    sw[0] = 1'b0;
    run_to(192); chk("rstmid_tick1", 8'(key_dn), 8'h0);
    run_to(193); chk("rstmid_tick2", 8'(key_dn), 8'h0);
    rst = 1'b1;
    #1;
    chk("rstmid_async_keydn", 8'(key_dn), 8'h0);
    chk("rstmid_async_tick", 8'(tick), 8'h0);
    adv();
    rst = 1'b0;
    run_to(4);  chk("rstmid_next_tick", 8'(key_dn), 8'h0);
    run_to(12); chk("rstmid_early", 8'(key_dn), 8'h0);
    run_to(13); chk("rstmid_keydn", 8'(key_dn), 8'h1);
    run_to(14); chk("rstmid_note", 8'(note), 8'h0);
    chk("rstmid_valid", 8'(note_valid), 8'h1);
    chk("rstmid_press", 8'(press), 8'h1);

    // 6: SW3 held and accepted, then higher-priority SW0 arrives
    run_to(16); sw[0] = 1'b1;
    run_to(30); chk("late_rel_keydn", 8'(key_dn), 8'h0);
    chk("late_rel_valid", 8'(note_valid), 8'h0);
    run_to(32); sw[3] = 1'b0;
    run_to(45); chk("late_sw3_keydn", 8'(key_dn), 8'h8);
    run_to(46); chk("late_sw3_note", 8'(note), 8'h3);
    chk("late_sw3_press", 8'(press), 8'h1);
    run_to(48); sw[0] = 1'b0;
    p0 = press_cnt;
    run_to(60); chk("late_sw0_early", 8'(key_dn), 8'h8);
    chk("late_sw0_note_hold", 8'(note), 8'h3);
    run_to(61); chk("late_sw0_keydn", 8'(key_dn), 8'h9);
    run_to(62); chk("late_sw0_note", 8'(note), 8'h0);
    chk("late_sw0_press", 8'(press), 8'h1);
    chk("late_sw0_valid", 8'(note_valid), 8'h1);
    run_to(63); chk("late_sw0_press_off", 8'(press), 8'h0);
    chk("late_press_count", 8'(press_cnt - p0), 8'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
# key_debounce

Upstream input stage for the piano tone generator. Synchronises the four raw active-low key switches, debounces each on a slow sample tick, and priority-encodes the held keys into a registered note index with a valid flag and a one-cycle press strobe. The tone generator consumes NOTE/NOTE_VALID in place of raw SW0–SW3, so contact bounce never reaches the divider selection.

## Interface
- TICK_DIV, 2500: CLK cycles per debounce sample tick; 20 kHz at 50 MHz CLK; ≥2.
- DEB_TICKS, 200: consecutive differing samples needed to accept a key change; 10 ms at 20 kHz; ≥1.
- CLK  input  1  system clock (M9); all logic on the rising edge.
- RST  input  1  reset, asynchronous, active-high; clears every register.
- SW0..SW3  input  1 each  raw key switches, active-low (0 = pressed), asynchronous to CLK.
- KEY_DN  output  4  debounced key state, active-high; bit i = SWi held.
- NOTE  output  2  index of the highest-priority held key.
- NOTE_VALID  output  1  at least one debounced key held.
- PRESS  output  1  one-cycle strobe: a new note started or the note index changed.
- TICK  output  1  one-cycle sample tick, exported for the tone generator's frame counter.

## Operation
- Reset values: sync flops 1 (released); KEY_DN 0; debounce counters 0; tick counter 0; NOTE 0; NOTE_VALID 0; PRESS 0; TICK 0.
- Synchroniser: two flops per key. raw_dn[i] = ~second flop.
- Tick counter: counts 0..TICK_DIV-1, then wraps to 0. TICK is registered and is 1 in the cycle after the counter reads TICK_DIV-1. With TICK_DIV=N, the first TICK after reset comes N cycles after RST deasserts, and it repeats every N cycles after that.
- Debounce: per-key counter, width clog2(DEB_TICKS)+1. Updates only in cycles where TICK=1:
  - raw_dn[i] == KEY_DN[i]: counter ← 0.
  - raw_dn[i] != KEY_DN[i] and counter == DEB_TICKS-1: KEY_DN[i] ← raw_dn[i], counter ← 0.
  - otherwise: counter ← counter+1.
  - A single agreeing sample discards all progress, so a bounce restarts the count.
- Priority encoder: lowest index wins (SW0 > SW1 > SW2 > SW3). next_valid = |KEY_DN. next_note = index of the lowest set bit, or 0 when none is set.
- Output register, updated every cycle:
  - NOTE ← next_note
  - NOTE_VALID ← next_valid
  - PRESS ← next_valid & (~NOTE_VALID | next_note != NOTE)
- Release of all keys: NOTE_VALID falls and NOTE returns to 0. PRESS stays 0.
- Release of the winning key while a lower-priority key is held: NOTE moves to that key and PRESS pulses once.
- Simultaneous presses accepted on the same tick: the higher-priority key wins, with a single PRESS.
- Reset mid-debounce: all progress is lost. After RST deasserts, a key that is still held needs the full DEB_TICKS again.

## Timing
- Raw edge → raw_dn: 2 cycles.
- raw_dn stable → KEY_DN change: on the DEB_TICKS-th TICK that samples the new value. Worst case about (DEB_TICKS+1)·TICK_DIV+2 cycles from the raw edge.
- KEY_DN → NOTE/NOTE_VALID/PRESS: 1 cycle. PRESS is high in exactly the cycle the new NOTE first appears.
- Outputs are glitch-free registers. No combinational path from SWx to any output.

## Test plan
Bench parameters: TICK_DIV=4, DEB_TICKS=3.

1. Reset:
   - Stimulus: RST=1 with all SW=1, then release RST.
   - Required: all outputs 0. TICK pulses at 4, 8, 12… cycles after release.
2. Clean press:
   - Stimulus: SW2 ← 0 and held.
   - Required: KEY_DN=4'b0100 on the 3rd TICK after raw_dn rises. Next cycle NOTE=2, NOTE_VALID=1, PRESS=1 for exactly one cycle.
   - Release SW2 the same way: NOTE_VALID=0, NOTE=0, no PRESS.
3. Bounce rejection:
   - Stimulus: SW0 toggles every 5 cycles for 60 cycles, then settles at 0.
   - Required: no KEY_DN change during the toggling. KEY_DN[0]=1 only after 3 consecutive low samples, with exactly one PRESS.
4. Priority and handover:
   - Stimulus: SW1 and SW3 pressed in the same cycle.
   - Required: NOTE=1 with one PRESS. Then release SW1: NOTE=3, PRESS pulses again, NOTE_VALID stays 1 throughout.
5. Reset mid-debounce:
   - Stimulus: SW0 held; assert RST for 1 cycle after the 2nd TICK.
   - Required: KEY_DN is still 0 at the next tick. It sets only on the 3rd TICK after RST deasserts.
6. Simultaneous acceptance with a higher-priority late press:
   - Stimulus: SW3 held and accepted (NOTE=3); then SW0 pressed.
   - Required: NOTE=0 and PRESS=1 once SW0 is debounced. KEY_DN=4'b1001.
